// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - fetch port and load status between the program loader and the PC stage
interface uart_prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              load_busy;
  logic              load_done;
  logic              frame_err;
  logic [ADDR_W:0]   wr_count;

  modport master (
    output rd_addr,
    input  rd_data, load_busy, load_done, frame_err, wr_count
  );

  modport slave (
    input  rd_addr,
    output rd_data, load_busy, load_done, frame_err, wr_count
  );
endinterface

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - 8N1 UART receiver loading a framed program (A5, N, data) into a DEPTH x 8 store
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               rx,
  uart_prog_loader_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] ONE     = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [2:0] {L_SYNC, L_LEN, L_DATA, L_CSUM, L_DONE} ld_state_t;

  rx_state_t        rx_state;
  ld_state_t        ld_state;
  logic             rx_s1, rx_s2, rx_q;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             byte_valid;
  logic             stop_err;
  logic [ADDR_W:0]  len;
  logic [7:0]       mem [DEPTH];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign bus.rd_data = mem[bus.rd_addr];

  // Receiver: rx_q is one more delayed copy of the synchronised line for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_q       <= 1'b1;
      rx_state   <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else if (ena) begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_q       <= rx_s2;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_q && !rx_s2) begin
            rx_state <= START;
            cnt      <= HALF_M1;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s2) begin
              rx_state <= DATA;
              cnt      <= FULL_M1;
              bit_idx  <= '0;
            end else begin
              rx_state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shift   <= {rx_s2, shift[7:1]};
            cnt     <= FULL_M1;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (rx_s2) byte_valid <= 1'b1;
            else       stop_err   <= 1'b1;
            rx_state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Loader: wr_count doubles as the write pointer since it restarts at 0 on every sync byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ld_state      <= L_SYNC;
      len           <= '0;
      bus.load_busy <= 1'b0;
      bus.load_done <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.wr_count  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else if (ena) begin
      if (stop_err) begin
        bus.frame_err <= 1'b1;
        if (ld_state == L_LEN || ld_state == L_DATA || ld_state == L_CSUM) begin
          ld_state      <= L_SYNC;
          bus.load_busy <= 1'b0;
        end
      end else if (byte_valid) begin
        case (ld_state)
          L_SYNC, L_DONE: begin
            if (shift == 8'hA5) begin
              ld_state      <= L_LEN;
              bus.load_busy <= 1'b1;
              bus.load_done <= 1'b0;
              bus.frame_err <= 1'b0;
              bus.wr_count  <= '0;
            end
          end
          L_LEN: begin
            if (shift == 8'h00 || shift > 8'(DEPTH)) begin
              ld_state      <= L_SYNC;
              bus.frame_err <= 1'b1;
              bus.load_busy <= 1'b0;
            end else begin
              len      <= shift[ADDR_W:0];
              ld_state <= L_DATA;
`ifdef LOADER_CHECKSUM_EN
              csum     <= '0;
`endif
            end
          end
          L_DATA: begin
            mem[bus.wr_count[ADDR_W-1:0]] <= shift;
            bus.wr_count <= bus.wr_count + ONE;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ shift;
            if (bus.wr_count + ONE == len) ld_state <= L_CSUM;
`else
            if (bus.wr_count + ONE == len) begin
              ld_state      <= L_DONE;
              bus.load_busy <= 1'b0;
              bus.load_done <= 1'b1;
            end
`endif
          end
          L_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
            bus.load_busy <= 1'b0;
            if (shift == csum) begin
              ld_state      <= L_DONE;
              bus.load_done <= 1'b1;
            end else begin
              ld_state      <= L_SYNC;
              bus.frame_err <= 1'b1;
            end
`else
            ld_state <= L_SYNC;
`endif
          end
          default: ld_state <= L_SYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - randomized frame-level check of uart_prog_loader against a store model
module tb_uart_prog_loader;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic rx = 1'b1;
  logic [AW-1:0] chk_addr = '0;
  logic [AW-1:0] sweep_addr = '0;
  bit sweep = 1'b0;
  bit chk_en = 1'b0;

  uart_prog_loader_if #(.ADDR_W(AW)) bus ();
  assign bus.rd_addr = sweep ? sweep_addr : chk_addr;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_mem [DEPTH];
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  int m_cnt = 0;
  logic [7:0] q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_at(input int a, output logic [7:0] v);
    sweep = 1'b1;
    sweep_addr = AW'(a);
    #1;
    v = bus.rd_data;
    sweep = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (CPB) tick();
  endtask

  // Frame-level expectation: what the store and flags must look like once the frame is over.
  task automatic model_frame(input logic [7:0] len, input int abort_at, input logic [7:0] cs);
    logic [7:0] x;
    x = 8'h00;
    if (len == 0 || len > DEPTH) begin
      m_err = 1'b1; m_done = 1'b0; m_cnt = 0;
      return;
    end
    for (int k = 0; k < len; k++) begin
      if (k == abort_at) begin
        m_err = 1'b1; m_done = 1'b0; m_cnt = k;
        return;
      end
      m_mem[k] = q[k];
      x ^= q[k];
    end
    m_cnt = len;
`ifdef LOADER_CHECKSUM_EN
    m_err = (cs != x);
    m_done = (cs == x);
`else
    m_err = 1'b0;
    m_done = 1'b1;
`endif
  endtask

  function automatic logic [7:0] xor_q(input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < n; k++) x ^= q[k];
    return x;
  endfunction

  task automatic do_frame(input logic [7:0] len, input int abort_at, input logic [7:0] cs, input bit pause);
    send_byte(8'hA5, 1'b1);
    send_byte(len, 1'b1);
    if (pause) begin
      ena = 1'b0;
      repeat (50) tick();
      check("pause_busy", bus.load_busy, 1);
      check("pause_count", bus.wr_count, 0);
      ena = 1'b1;
    end
    if (len != 0 && len <= DEPTH) begin
      for (int k = 0; k < len; k++) begin
        if (k == abort_at) begin
          send_byte(q[k], 1'b0);
          break;
        end
        send_byte(q[k], 1'b1);
      end
`ifdef LOADER_CHECKSUM_EN
      if (abort_at < 0) send_byte(cs, 1'b1);
`endif
    end
    model_frame(len, abort_at, cs);
  endtask

  task automatic settle();
    repeat (2 * CPB) tick();
    chk_en = 1'b1;
    repeat (12) tick();
    chk_en = 1'b0;
  endtask

  // Compare process: between frames every output must match the model at a random fetch address.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk_addr = AW'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
      if (chk_en && !sweep && rst_n) begin
        check("rd_data", bus.rd_data, m_mem[chk_addr]);
        check("load_busy", bus.load_busy, 0);
        check("load_done", bus.load_done, m_done);
        check("frame_err", bus.frame_err, m_err);
        check("wr_count", bus.wr_count, m_cnt);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int kind, len, ab;
    logic [7:0] cs;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

    #1;
    check("rst_busy", bus.load_busy, 0);
    check("rst_done", bus.load_done, 0);
    check("rst_err", bus.frame_err, 0);
    check("rst_count", bus.wr_count, 0);
    read_at(5, v);
    check("rst_mem5", v, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();

    // Clean load with hand-computed results.
    q.delete(); q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    do_frame(8'd3, -1, 8'h00, 1'b0);
    settle();
    check("clean_done", bus.load_done, 1);
    check("clean_count", bus.wr_count, 3);
    read_at(0, v); check("clean_mem0", v, 8'h11);
    read_at(1, v); check("clean_mem1", v, 8'h22);
    read_at(2, v); check("clean_mem2", v, 8'h33);
    read_at(3, v); check("clean_mem3", v, 8'h00);

    // Glitch in idle: no byte, no error.
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    settle();
    check("glitch_err", bus.frame_err, 0);
    q.delete(); q.push_back(8'h7E);
    do_frame(8'd1, -1, 8'h7E, 1'b0);
    settle();
    read_at(0, v); check("glitch_mem0", v, 8'h7E);

    // Bad lengths.
    q.delete();
    do_frame(8'h00, -1, 8'h00, 1'b0);
    settle();
    check("len0_err", bus.frame_err, 1);
    do_frame(8'h11, -1, 8'h00, 1'b0);
    settle();
    check("len17_err", bus.frame_err, 1);
    read_at(1, v); check("len17_mem1", v, 8'h22);

    // Stop bit low on the third data byte (0x55).
    q.delete(); q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h55); q.push_back(8'h04);
    do_frame(8'd4, 2, 8'h00, 1'b0);
    settle();
    check("framing_err", bus.frame_err, 1);
    check("framing_count", bus.wr_count, 2);
    read_at(2, v); check("framing_mem2", v, 8'h33);
    q.delete(); q.push_back(8'hAA); q.push_back(8'hBB);
    do_frame(8'd2, -1, 8'h11, 1'b1);
    settle();
    check("after_framing_done", bus.load_done, 1);

`ifdef LOADER_CHECKSUM_EN
    q.delete(); q.push_back(8'h0F); q.push_back(8'hF0);
    do_frame(8'd2, -1, 8'hFE, 1'b0);
    settle();
    check("csum_bad_err", bus.frame_err, 1);
    check("csum_bad_done", bus.load_done, 0);
    do_frame(8'd2, -1, 8'hFF, 1'b0);
    settle();
    check("csum_good_done", bus.load_done, 1);
`endif

    // Randomized frames.
    for (int it = 0; it < 10; it++) begin
      kind = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, DEPTH));
      q.delete();
      for (int k = 0; k < len; k++) q.push_back(8'($urandom));
      cs = xor_q(len);
      if ($urandom_range(0, 3) == 0) cs = cs ^ 8'h01;
      ab = -1;
      if (kind == 1) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(DEPTH + 1, 255));
      end else if (kind == 2) begin
        ab = int'($urandom_range(0, len - 1));
      end else if (kind == 3) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          v = 8'($urandom);
          if (v == 8'hA5) v = 8'h5A;
          send_byte(v, 1'b1);
        end
      end
      do_frame(8'(len), ab, cs, 1'b0);
      settle();
    end

    // Asynchronous reset in the middle of a frame.
    q.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    check("mid_busy", bus.load_busy, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", bus.load_busy, 0);
    check("arst_done", bus.load_done, 0);
    check("arst_err", bus.frame_err, 0);
    check("arst_count", bus.wr_count, 0);
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a, v);
      check("arst_mem", v, 8'h00);
    end
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_done = 1'b0; m_err = 1'b0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
